// File: rtl/dec_syndrome.sv
// -----------------------------------------------------------------------------
// dec_syndrome
//
// Syndrome-generation stage of the ECC decode path. A received codeword is
// masked to the length of its work mode (S1), then the parity-check syndrome
// against that mode's H matrix is computed and registered together with the
// codeword, mode and an illegal-mode flag (S2). S2 registers drive the
// outputs directly. Two-entry pipeline with valid/ready on both sides.
//
// Optional feature macro: DEC_SYN_ERR_CNT_EN
//   When defined, adds cnt_clr / err_cnt: a saturating 16-bit count of
//   delivered words whose syndrome is non-zero.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   in_valid      in   upstream word present
//   in_ready      out  stage can accept a word this cycle
//   data_in       in   received codeword, LSB aligned
//   work_mod_in   in   00: 8b, 01: 16b, 10: 32b, 11: illegal
//   out_valid     out  result present
//   out_ready     in   downstream accepts
//   data_out      out  masked codeword
//   s_vector      out  syndrome, unused MSBs zero
//   work_mod_out  out  mode travelling with the word
//   illegal_mod   out  word was submitted with mode 11
//   cnt_clr       in   synchronous clear of err_cnt   (DEC_SYN_ERR_CNT_EN)
//   err_cnt       out  non-zero-syndrome word count   (DEC_SYN_ERR_CNT_EN)
// -----------------------------------------------------------------------------
module dec_syndrome #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0]                data_in,
   input  logic [1:0]                                   work_mod_in,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0]                data_out,
   output logic [MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH-1:0] s_vector,
   output logic [1:0]                                   work_mod_out,
   output logic                                         illegal_mod
`ifdef DEC_SYN_ERR_CNT_EN
   ,
   input  logic                                         cnt_clr,
   output logic [15:0]                                  err_cnt
`endif
);

   localparam int CW = MAX_CODEWORD_WIDTH;
   localparam int P  = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

   // H matrix rows; row r produces syndrome bit r.
   localparam logic [31:0] H8_R0  = 32'h0000_00B1;
   localparam logic [31:0] H8_R1  = 32'h0000_00D2;
   localparam logic [31:0] H8_R2  = 32'h0000_00E4;
   localparam logic [31:0] H8_R3  = 32'h0000_00FF;
   localparam logic [31:0] H16_R0 = 32'h0000_AB61;
   localparam logic [31:0] H16_R1 = 32'h0000_CDA2;
   localparam logic [31:0] H16_R2 = 32'h0000_F1C4;
   localparam logic [31:0] H16_R3 = 32'h0000_FE08;
   localparam logic [31:0] H16_R4 = 32'h0000_FFFF;
   localparam logic [31:0] H32_R0 = 32'hAAAB_56C1;
   localparam logic [31:0] H32_R1 = 32'hCCCD_9B42;
   localparam logic [31:0] H32_R2 = 32'hF0F1_E384;
   localparam logic [31:0] H32_R3 = 32'hFF01_FC08;
   localparam logic [31:0] H32_R4 = 32'hFFFE_0010;
   localparam logic [31:0] H32_R5 = 32'hFFFF_FFFF;

   // Clear bits beyond the mode's codeword length; the illegal mode passes
   // the word through untouched so downstream can inspect it.
   function automatic logic [CW-1:0] mask_word(input logic [CW-1:0] d,
                                               input logic [1:0]    m);
      logic [CW-1:0] r;
      case (m)
         2'b00:   r = d & CW'(32'h0000_00FF);
         2'b01:   r = d & CW'(32'h0000_FFFF);
         default: r = d;
      endcase
      return r;
   endfunction

   // Parity of the word against each H row of the mode. Rows the mode does
   // not have stay 0, and the illegal mode yields an all-zero syndrome.
   function automatic logic [P-1:0] calc_syndrome(input logic [CW-1:0] d,
                                                  input logic [1:0]    m);
      logic [31:0] dw;
      logic [5:0]  s;
      dw = 32'(d);
      s  = '0;
      case (m)
         2'b00: begin
            s[0] = ^(dw & H8_R0);
            s[1] = ^(dw & H8_R1);
            s[2] = ^(dw & H8_R2);
            s[3] = ^(dw & H8_R3);
         end
         2'b01: begin
            s[0] = ^(dw & H16_R0);
            s[1] = ^(dw & H16_R1);
            s[2] = ^(dw & H16_R2);
            s[3] = ^(dw & H16_R3);
            s[4] = ^(dw & H16_R4);
         end
         2'b10: begin
            s[0] = ^(dw & H32_R0);
            s[1] = ^(dw & H32_R1);
            s[2] = ^(dw & H32_R2);
            s[3] = ^(dw & H32_R3);
            s[4] = ^(dw & H32_R4);
            s[5] = ^(dw & H32_R5);
         end
         default: s = '0;
      endcase
      return P'(s);
   endfunction

   logic          vld_p1, vld_p2;
   logic          adv_p1, adv_p2;
   logic [CW-1:0] data_p1, data_p2;
   logic [1:0]    mode_p1, mode_p2;
   logic [P-1:0]  syn_p2;
   logic          ill_p2;

   // A stage may load when it is empty or its occupant moves on this cycle.
   // in_ready depends only on out_ready and the valid bits.
   assign adv_p2   = !vld_p2 || out_ready;
   assign adv_p1   = !vld_p1 || adv_p2;
   assign in_ready = adv_p1;

   // ---- Stage 1: mode mask --------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         mode_p1 <= 2'b00;
      end else begin
         if (adv_p1) vld_p1 <= in_valid;
         if (adv_p1 && in_valid) begin
            data_p1 <= mask_word(data_in, work_mod_in);
            mode_p1 <= work_mod_in;
         end
      end
   end

   // ---- Stage 2: syndrome, registered outputs --------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         syn_p2  <= '0;
         mode_p2 <= 2'b00;
         ill_p2  <= 1'b0;
      end else begin
         if (adv_p2) vld_p2 <= vld_p1;
         if (adv_p2 && vld_p1) begin
            data_p2 <= data_p1;
            syn_p2  <= calc_syndrome(data_p1, mode_p1);
            mode_p2 <= mode_p1;
            ill_p2  <= (mode_p1 == 2'b11);
         end
      end
   end

   assign out_valid    = vld_p2;
   assign data_out     = data_p2;
   assign s_vector     = syn_p2;
   assign work_mod_out = mode_p2;
   assign illegal_mod  = ill_p2;

`ifdef DEC_SYN_ERR_CNT_EN
   // Counts delivered words only; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= 16'd0;
      end else if (cnt_clr) begin
         err_cnt <= 16'd0;
      end else if (vld_p2 && out_ready && (syn_p2 != '0) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dec_syndrome.sv
module tb_dec_syndrome;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [1:0]  work_mod_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic [5:0]  s_vector;
   logic [1:0]  work_mod_out;
   logic        illegal_mod;
`ifdef DEC_SYN_ERR_CNT_EN
   logic        cnt_clr;
   logic [15:0] err_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] d;
      logic [5:0]  s;
      logic [1:0]  m;
      logic        ill;
   } exp_t;

   dec_syndrome dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_in      (data_in),
      .work_mod_in  (work_mod_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data_out     (data_out),
      .s_vector     (s_vector),
      .work_mod_out (work_mod_out),
      .illegal_mod  (illegal_mod)
`ifdef DEC_SYN_ERR_CNT_EN
      ,
      .cnt_clr      (cnt_clr),
      .err_cnt      (err_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic int cw_len(input logic [1:0] m);
      case (m)
         2'b00:   return 8;
         2'b01:   return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int n_par(input logic [1:0] m);
      case (m)
         2'b00:   return 4;
         2'b01:   return 5;
         2'b10:   return 6;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] h_row(input logic [1:0] m, input int r);
      logic [31:0] t [6];
      case (m)
         2'b00:   t = '{32'hB1, 32'hD2, 32'hE4, 32'hFF, 32'h0, 32'h0};
         2'b01:   t = '{32'hAB61, 32'hCDA2, 32'hF1C4, 32'hFE08, 32'hFFFF, 32'h0};
         default: t = '{32'hAAAB56C1, 32'hCCCD9B42, 32'hF0F1E384,
                        32'hFF01FC08, 32'hFFFE0010, 32'hFFFFFFFF};
      endcase
      return t[r];
   endfunction

   function automatic exp_t ref_word(input logic [31:0] d, input logic [1:0] m);
      exp_t e;
      int   len;
      len   = cw_len(m);
      e.m   = m;
      e.ill = (m == 2'b11);
      if (m == 2'b11 || len >= 32) e.d = d;
      else                         e.d = d & ((32'd1 << len) - 32'd1);
      e.s = 6'd0;
      for (int r = 0; r < n_par(m); r++)
         e.s[r] = (($countones(e.d & h_row(m, r)) % 2) == 1);
      return e;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      data_in = 32'd0; work_mod_in = 2'b00;
`ifdef DEC_SYN_ERR_CNT_EN
      cnt_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if ({data_out, s_vector, work_mod_out, illegal_mod} !== 41'd0) begin
         n_fail++; $display("FAIL rst_outputs: got %h/%h/%b/%b expected all zero", data_out, s_vector, work_mod_out, illegal_mod); end
`ifdef DEC_SYN_ERR_CNT_EN
      n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
`endif
      rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] td [6];
      logic [1:0]  tm [6];
      logic [31:0] xd [6];
      logic [5:0]  xs [6];
      logic        xi [6];
      td = '{32'h00000001, 32'h80000000, 32'h00000000, 32'h00FF0000, 32'h12345678, 32'hFFFFFF80};
      tm = '{2'b00,        2'b10,        2'b10,        2'b01,        2'b11,        2'b00};
      xd = '{32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 32'h12345678, 32'h00000080};
      xs = '{6'h09,        6'h3F,        6'h00,        6'h00,        6'h00,        6'h0F};
      xi = '{1'b0,         1'b0,         1'b0,         1'b0,         1'b1,         1'b0};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; data_in = td[i]; work_mod_in = tm[i]; out_ready = 1'b1;
         @(negedge clk);
         n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0; data_in = $urandom;
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_out_valid: got %b expected 1", i, out_valid); end
         n_cmp++; if (data_out !== xd[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h expected %h", i, data_out, xd[i]); end
         n_cmp++; if (s_vector !== xs[i]) begin n_fail++; $display("FAIL dir%0d_syn: got %h expected %h", i, s_vector, xs[i]); end
         n_cmp++; if (work_mod_out !== tm[i]) begin n_fail++; $display("FAIL dir%0d_mode: got %b expected %b", i, work_mod_out, tm[i]); end
         n_cmp++; if (illegal_mod !== xi[i]) begin n_fail++; $display("FAIL dir%0d_illegal: got %b expected %b", i, illegal_mod, xi[i]); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      exp_t        q [$];
      exp_t        e;
      logic [31:0] pd;
      logic [1:0]  pm;
      int          sent = 0, got = 0, done_c = -1;
      for (int c = 0; c < 40 && got < 20; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         pd = $urandom; pm = 2'($urandom_range(0, 3));
         in_valid = (sent < 20); data_in = pd; work_mod_in = pm;
         @(negedge clk);
         n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b expected 1", c, in_ready); end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL b2b_extra_word c%0d: got data %h expected none", c, data_out);
            end else begin
               e = q.pop_front();
               n_cmp++;
               if ({data_out, s_vector, work_mod_out, illegal_mod} !== {e.d, e.s, e.m, e.ill}) begin
                  n_fail++; $display("FAIL b2b_word%0d: got %h/%h/%b/%b expected %h/%h/%b/%b",
                                     got, data_out, s_vector, work_mod_out, illegal_mod, e.d, e.s, e.m, e.ill);
               end
               got++;
               if (got == 20) done_c = c;
            end
         end
         if (in_valid && in_ready) begin q.push_back(ref_word(pd, pm)); sent++; end
      end
      in_valid = 1'b0;
      n_cmp++; if (done_c != 21) begin n_fail++; $display("FAIL b2b_throughput: got last word at cycle %0d expected 21", done_c); end
   endtask

   task automatic test_stall();
      exp_t        q [$];
      exp_t        e;
      logic [31:0] pd;
      logic [1:0]  pm;
      logic [41:0] prev_o;
      bit          have = 0, saw_low = 0, prev_stall = 0;
      int          sent = 0, got = 0, n;
      for (int c = 0; c < 60 && got < 10; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 3 && c <= 7);
         if (!have && sent < 10) begin pd = $urandom; pm = 2'($urandom_range(0, 2)); have = 1; end
         in_valid = have; data_in = pd; work_mod_in = pm;
         @(negedge clk);
         n = q.size();
         n_cmp++; if (in_ready !== ((n < 2) || out_ready)) begin
            n_fail++; $display("FAIL stall_in_ready c%0d: got %b expected %b", c, in_ready, (n < 2) || out_ready); end
         if (!in_ready) saw_low = 1;
         if (n == 2) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_full_valid c%0d: got %b expected 1", c, out_valid); end
         end
         if (prev_stall) begin
            n_cmp++; if ({out_valid, illegal_mod, work_mod_out, s_vector, data_out} !== prev_o) begin
               n_fail++; $display("FAIL stall_stable c%0d: got %h expected %h", c,
                                  {out_valid, illegal_mod, work_mod_out, s_vector, data_out}, prev_o); end
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL stall_extra_word c%0d: got data %h expected none", c, data_out);
            end else begin
               e = q.pop_front();
               n_cmp++;
               if ({data_out, s_vector, work_mod_out, illegal_mod} !== {e.d, e.s, e.m, e.ill}) begin
                  n_fail++; $display("FAIL stall_word%0d: got %h/%h/%b/%b expected %h/%h/%b/%b",
                                     got, data_out, s_vector, work_mod_out, illegal_mod, e.d, e.s, e.m, e.ill);
               end
               got++;
            end
         end
         if (in_valid && in_ready) begin q.push_back(ref_word(pd, pm)); sent++; have = 0; end
         prev_stall = out_valid && !out_ready;
         prev_o     = {out_valid, illegal_mod, work_mod_out, s_vector, data_out};
      end
      in_valid = 1'b0;
      n_cmp++; if (got != 10) begin n_fail++; $display("FAIL stall_count: got %0d expected 10", got); end
      n_cmp++; if (saw_low != 1'b1) begin n_fail++; $display("FAIL stall_ready_drop: got %b expected 1", saw_low); end
   endtask

   task automatic test_random();
      exp_t        q [$];
      exp_t        e;
      logic [31:0] pd;
      logic [1:0]  pm;
      logic [41:0] prev_o;
      bit          have = 0, prev_stall = 0;
      int          sent = 0, got = 0, n;
      int          exp_cnt = 0;
`ifdef DEC_SYN_ERR_CNT_EN
      @(posedge clk); #1; cnt_clr = 1'b1;
      @(posedge clk); #1; cnt_clr = 1'b0;
`endif
      for (int c = 0; c < 3000 && got < 300; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 9) < 7);
         if (!have && sent < 300 && $urandom_range(0, 3) != 0) begin
            pd = $urandom; pm = 2'($urandom_range(0, 3)); have = 1;
         end
         in_valid = have; data_in = pd; work_mod_in = pm;
         @(negedge clk);
         n = q.size();
         n_cmp++; if (in_ready !== ((n < 2) || out_ready)) begin
            n_fail++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, (n < 2) || out_ready); end
         if (n == 0) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty_valid c%0d: got %b expected 0", c, out_valid); end
         end
         if (prev_stall) begin
            n_cmp++; if ({out_valid, illegal_mod, work_mod_out, s_vector, data_out} !== prev_o) begin
               n_fail++; $display("FAIL rnd_stable c%0d: got %h expected %h", c,
                                  {out_valid, illegal_mod, work_mod_out, s_vector, data_out}, prev_o); end
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL rnd_extra_word c%0d: got data %h expected none", c, data_out);
            end else begin
               e = q.pop_front();
               n_cmp++;
               if ({data_out, s_vector, work_mod_out, illegal_mod} !== {e.d, e.s, e.m, e.ill}) begin
                  n_fail++; $display("FAIL rnd_word%0d: got %h/%h/%b/%b expected %h/%h/%b/%b",
                                     got, data_out, s_vector, work_mod_out, illegal_mod, e.d, e.s, e.m, e.ill);
               end
               if (e.s != 6'd0) exp_cnt++;
               got++;
            end
         end
         if (in_valid && in_ready) begin q.push_back(ref_word(pd, pm)); sent++; have = 0; end
         prev_stall = out_valid && !out_ready;
         prev_o     = {out_valid, illegal_mod, work_mod_out, s_vector, data_out};
      end
      in_valid = 1'b0;
      n_cmp++; if (got != 300) begin n_fail++; $display("FAIL rnd_count: got %0d expected 300", got); end
      @(posedge clk); #1;
      @(negedge clk);
`ifdef DEC_SYN_ERR_CNT_EN
      n_cmp++; if (err_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt: got %0d expected %0d", err_cnt, exp_cnt); end
`else
      if (exp_cnt < 0) $display("unreachable");
`endif
   endtask

`ifdef DEC_SYN_ERR_CNT_EN
   task automatic test_err_cnt();
      logic [31:0] td [5];
      logic [1:0]  tm [5];
      exp_t        e;
      int          exp_cnt = 0;
      td = '{32'h00000001, 32'h00000000, 32'h80000000, 32'h00FF0000, 32'h00000001};
      tm = '{2'b00,        2'b10,        2'b10,        2'b01,        2'b01};
      @(posedge clk); #1; cnt_clr = 1'b1;
      @(posedge clk); #1; cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e = ref_word(td[i], tm[i]);
         if (e.s != 6'd0) exp_cnt++;
         in_valid = 1'b1; data_in = td[i]; work_mod_in = tm[i]; out_ready = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (err_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL cnt_value: got %0d expected %0d", err_cnt, exp_cnt); end
      n_cmp++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL cnt_three: got %0d expected 3", err_cnt); end
      cnt_clr = 1'b1;
      @(posedge clk); #1; cnt_clr = 1'b0;
      @(negedge clk);
      n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", err_cnt); end
   endtask
`endif

   task automatic test_reset_midstream();
      @(posedge clk); #1;
      in_valid = 1'b1; data_in = 32'h00000001; work_mod_in = 2'b00; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; data_in = 32'h80000000; work_mod_in = 2'b10;
      @(posedge clk); #1;
      in_valid = 1'b1; data_in = 32'h00000003; work_mod_in = 2'b01; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
      n_cmp++; if ({data_out, s_vector, work_mod_out, illegal_mod} !== 41'd0) begin
         n_fail++; $display("FAIL mid_rst_outputs: got %h/%h/%b/%b expected all zero", data_out, s_vector, work_mod_out, illegal_mod); end
`ifdef DEC_SYN_ERR_CNT_EN
      n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_err_cnt: got %0d expected 0", err_cnt); end
`endif
      #1 rst = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random();
`ifdef DEC_SYN_ERR_CNT_EN
      test_err_cnt();
`endif
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dec_syndrome.md
# dec_syndrome

Syndrome-generation stage sitting directly upstream of the decoder check/correct stage in the ECC decode path. It accepts a received codeword and its work mode, and masks off bits beyond the mode's codeword length. It computes the parity-check syndrome against the mode's H matrix and presents codeword, syndrome and mode together to the downstream stage. Two-stage pipeline with valid/ready flow control in both directions; full throughput, stall-safe.

## Interface
- MAX_CODEWORD_WIDTH, 32, widest codeword (work_mod 2'b10)
- MAX_INFO_WIDTH, 26, widest info field; parity width P = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH = 6
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  upstream word present
- in_ready  out  1  block can accept this cycle
- data_in  in  32  received codeword, LSB-aligned
- work_mod_in  in  2  00: 8b (4 info/4 parity), 01: 16b (11/5), 10: 32b (26/6), 11: illegal
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- data_out  out  32  masked codeword
- s_vector  out  6  syndrome, unused MSBs zero
- work_mod_out  out  2  mode travelling with the word
- illegal_mod  out  1  word was submitted with work_mod 11
- cnt_clr  in  1  synchronous clear of err_cnt (present only with DEC_SYN_ERR_CNT_EN)
- err_cnt  out  16  count of delivered words with non-zero syndrome (present only with DEC_SYN_ERR_CNT_EN)

## Operation
- H rows, row 0 = s_vector[0]. Mode 00: B1, D2, E4, FF. Mode 01: AB61, CDA2, F1C4, FE08, FFFF. Mode 10: AAAB56C1, CCCD9B42, F0F1E384, FF01FC08, FFFE0010, FFFFFFFF.
- Stage 1 (S1): on accept, registers data_in ANDed with the mode mask (mode 00: bits 7:0; 01: 15:0; 10: 31:0; 11: unmasked). It also registers the mode and sets s1_valid.
- Stage 2 (S2): s_vector[r] = XOR-reduce(S1 data AND row r), over the rows of the mode. Rows beyond the mode's parity width give 0. Mode 11 gives s_vector = 0 and illegal_mod = 1.
- S2 registers data, syndrome, mode and illegal flag, and drives them directly as outputs. out_valid = s2_valid.
- Flow control:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from out_ready and the valid bits; no path from in_valid.
- S2 loads when adv2 && s1_valid. s2_valid clears when out_ready && !s1_valid.
- While out_valid && !out_ready, all outputs stay bit-stable.
- Transfer on each side occurs only when valid && ready are high in the same cycle.
- Reset (rst low, any time, including mid-stall): s1_valid = s2_valid = 0, and all data/syndrome/mode registers = 0.
  - Outputs therefore read out_valid 0, data_out 0, s_vector 0, work_mod_out 00, illegal_mod 0, err_cnt 0.
  - in_ready reads 1 while in reset, because both stages are empty.
  - Words in flight are dropped.

## Timing
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N+2, when out_ready is held high.
- Throughput: one word per cycle, sustained.
- Backpressure: with out_ready low and both stages full, in_ready drops in the same cycle. At most 2 words are buffered, and none is lost or duplicated.
- A simultaneous output transfer and input accept while full is legal; the pipeline shifts by one.
- Release from backpressure: in_ready returns in the same cycle that out_ready rises.

## Configuration
- DEC_SYN_ERR_CNT_EN defined:
  - err_cnt and cnt_clr exist.
  - err_cnt increments on each output transfer with s_vector != 0 and saturates at 0xFFFF.
  - cnt_clr has priority over increment; counter reads 0 the cycle after clear.
- Undefined: neither port nor the counter logic exists; all other behaviour is unchanged.

## Test plan
- Mode 00, data_in 0x00000001, out_ready = 1 -> two cycles later: data_out 0x00000001, s_vector 6'h09, work_mod_out 00.
- Mode 10, data_in 0x80000000 -> s_vector 6'h3F; mode 10, data_in 0x00000000 -> s_vector 6'h00.
- Mode 01, data_in 0x00FF0000 -> data_out 0x00000000, s_vector 6'h00 (upper bits masked).
- Mode 11, data_in 0x12345678 -> data_out 0x12345678, s_vector 0, illegal_mod 1.
- Stream of 10 words with out_ready low for cycles 3-7:
  - in_ready falls once 2 words are buffered.
  - Outputs stay stable during the stall.
  - All 10 words arrive in order with correct syndromes.
- With DEC_SYN_ERR_CNT_EN defined, 3 erroneous words and 2 clean words -> err_cnt = 3.
  - Pulsing cnt_clr then reads 0.
  - Pulsing rst low mid-stream clears out_valid and err_cnt immediately.
